// File: rtl/exe_alu_stage.sv
// ============================================================================
// Module   : exe_alu_stage
// Purpose  : EXE-stage ALU, NZCV status register and EXE/MEM output register.
//            An iterative multiplier is added when ALU_MUL_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module exe_alu_stage #(
  parameter int DW = 32,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    exe_cmd,
  input  logic          s_bit,
  input  logic [DW-1:0] val1,
  input  logic [DW-1:0] val2,
  input  logic [RW-1:0] dest_in,
  input  logic [2:0]    ctl_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] alu_res,
  output logic [RW-1:0] dest_out,
  output logic [2:0]    ctl_out,
  output logic [3:0]    status
);

  localparam logic [3:0] c_op_mov = 4'b0001;
  localparam logic [3:0] c_op_add = 4'b0010;
  localparam logic [3:0] c_op_adc = 4'b0011;
  localparam logic [3:0] c_op_sub = 4'b0100;
  localparam logic [3:0] c_op_sbc = 4'b0101;
  localparam logic [3:0] c_op_and = 4'b0110;
  localparam logic [3:0] c_op_orr = 4'b0111;
  localparam logic [3:0] c_op_eor = 4'b1000;
  localparam logic [3:0] c_op_mvn = 4'b1001;

  logic          r_out_valid;
  logic [DW-1:0] r_alu_res;
  logic [RW-1:0] r_dest;
  logic [2:0]    r_ctl;
  logic [3:0]    r_status;

  logic          w_free;
  logic          w_idle;
  logic          w_accept;
  logic          w_alu_load;
  logic          w_mul_go;
  logic          w_mul_load;
  logic [DW-1:0] w_mul_res;
  logic [RW-1:0] w_mul_dest;
  logic [2:0]    w_mul_ctl;
  logic          w_mul_s;

  logic [DW:0]   w_wide;
  logic [DW-1:0] w_res;
  logic          w_upd;
  logic          w_c;
  logic          w_v;

  assign w_free     = ~r_out_valid | out_ready;
  assign in_ready   = w_free & w_idle;
  assign w_accept   = in_valid & in_ready & ~flush;
  assign w_alu_load = w_accept & ~w_mul_go;

  // Carry and overflow default to the held flags so logic ops leave them alone.
  always_comb begin
    w_wide = '0;
    w_res  = '0;
    w_upd  = 1'b1;
    w_c    = r_status[1];
    w_v    = r_status[0];
    case (exe_cmd)
      c_op_mov: w_res = val2;
      c_op_mvn: w_res = ~val2;
      c_op_and: w_res = val1 & val2;
      c_op_orr: w_res = val1 | val2;
      c_op_eor: w_res = val1 ^ val2;
      c_op_add, c_op_adc: begin
        w_wide = {1'b0, val1} + {1'b0, val2}
               + {{DW{1'b0}}, (exe_cmd == c_op_adc) & r_status[1]};
        w_res  = w_wide[DW-1:0];
        w_c    = w_wide[DW];
        w_v    = (val1[DW-1] == val2[DW-1]) & (w_res[DW-1] != val1[DW-1]);
      end
      c_op_sub, c_op_sbc: begin
        w_wide = {1'b0, val1} - {1'b0, val2}
               - {{DW{1'b0}}, (exe_cmd == c_op_sbc) & ~r_status[1]};
        w_res  = w_wide[DW-1:0];
        w_c    = ~w_wide[DW];
        w_v    = (val1[DW-1] != val2[DW-1]) & (w_res[DW-1] != val1[DW-1]);
      end
      default: w_upd = 1'b0;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam logic [3:0] c_op_mul = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_mcand;
  logic [DW-1:0] r_mplier;
  logic [DW-1:0] r_prod;
  logic [4:0]    r_cnt;
  logic [RW-1:0] r_mdest;
  logic [2:0]    r_mctl;
  logic          r_ms;

  assign w_idle     = (r_state == S_IDLE);
  assign w_mul_go   = w_accept & (exe_cmd == c_op_mul);
  assign w_mul_load = (r_state == S_WAIT) & w_free & ~flush;
  assign w_mul_res  = r_prod;
  assign w_mul_dest = r_mdest;
  assign w_mul_ctl  = r_mctl;
  assign w_mul_s    = r_ms;

  // Shift-add: one multiplier bit per cycle, 32 cycles, then wait for the output slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_mdest  <= '0;
      r_mctl   <= '0;
      r_ms     <= 1'b0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mul_go) begin
            r_state  <= S_MUL;
            r_mcand  <= val1;
            r_mplier <= val2;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_mdest  <= dest_in;
            r_mctl   <= ctl_in;
            r_ms     <= s_bit;
          end
        end
        S_MUL: begin
          if (r_mplier[0]) r_prod <= r_prod + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_free) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`else
  assign w_idle     = 1'b1;
  assign w_mul_go   = 1'b0;
  assign w_mul_load = 1'b0;
  assign w_mul_res  = '0;
  assign w_mul_dest = '0;
  assign w_mul_ctl  = '0;
  assign w_mul_s    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_alu_res   <= '0;
      r_dest      <= '0;
      r_ctl       <= '0;
      r_status    <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_alu_load) begin
      r_out_valid <= 1'b1;
      r_alu_res   <= w_res;
      r_dest      <= dest_in;
      r_ctl       <= ctl_in;
      if (s_bit && w_upd) r_status <= {w_res[DW-1], (w_res == '0), w_c, w_v};
    end else if (w_mul_load) begin
      r_out_valid <= 1'b1;
      r_alu_res   <= w_mul_res;
      r_dest      <= w_mul_dest;
      r_ctl       <= w_mul_ctl;
      if (w_mul_s) r_status <= {w_mul_res[DW-1], (w_mul_res == '0), r_status[1:0]};
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign alu_res   = r_alu_res;
  assign dest_out  = r_dest;
  assign ctl_out   = r_ctl;
  assign status    = r_status;

endmodule

`default_nettype wire

// File: tb/tb_exe_alu_stage.sv
// ============================================================================
// Module   : tb_exe_alu_stage
// Purpose  : Self-checking bench for exe_alu_stage (ALU_MUL_EN aware).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_exe_alu_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  exe_cmd;
  logic        s_bit;
  logic [31:0] val1;
  logic [31:0] val2;
  logic [3:0]  dest_in;
  logic [2:0]  ctl_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_res;
  logic [3:0]  dest_out;
  logic [2:0]  ctl_out;
  logic [3:0]  status;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  exe_alu_stage #(.DW(32), .RW(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .exe_cmd(exe_cmd), .s_bit(s_bit), .val1(val1), .val2(val2),
    .dest_in(dest_in), .ctl_in(ctl_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_res(alu_res), .dest_out(dest_out), .ctl_out(ctl_out),
    .status(status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic        m_valid = 1'b0;
  logic [31:0] m_res   = '0;
  logic [3:0]  m_dest  = '0;
  logic [2:0]  m_ctl   = '0;
  logic [3:0]  m_nzcv  = '0;
  logic        m_busy  = 1'b0;
  int          m_left  = 0;
  logic [31:0] m_prod  = '0;
  logic [3:0]  m_pd    = '0;
  logic [2:0]  m_pc    = '0;
  logic        m_ps    = 1'b0;
  logic [35:0] m_next;

  // Returns {new_nzcv, result}; flags come back unchanged for undefined opcodes.
  function automatic logic [35:0] core(input logic [3:0] cmd, input logic [31:0] a,
                                       input logic [31:0] b, input logic [3:0] f);
    longint u, sv, ci;
    logic [31:0] r;
    logic c, v, upd;
    ci = f[1] ? 64'sd1 : 64'sd0;
    r = '0; c = f[1]; v = f[0]; upd = 1'b1;
    case (cmd)
      4'd1: r = b;
      4'd9: r = ~b;
      4'd6: r = a & b;
      4'd7: r = a | b;
      4'd8: r = a ^ b;
      4'd2, 4'd3: begin
        u  = longint'(a) + longint'(b) + ((cmd == 4'd3) ? ci : 64'sd0);
        sv = longint'($signed(a)) + longint'($signed(b)) + ((cmd == 4'd3) ? ci : 64'sd0);
        r  = u[31:0];
        c  = (u >= 64'sh1_0000_0000);
        v  = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      end
      4'd4, 4'd5: begin
        u  = longint'(a) - longint'(b) - ((cmd == 4'd5) ? (64'sd1 - ci) : 64'sd0);
        sv = longint'($signed(a)) - longint'($signed(b)) - ((cmd == 4'd5) ? (64'sd1 - ci) : 64'sd0);
        r  = u[31:0];
        c  = (u >= 64'sd0);
        v  = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      end
      default: upd = 1'b0;
    endcase
    return {(upd ? {r[31], (r == 32'd0), c, v} : f), r};
  endfunction

  function automatic logic is_mul(input logic [3:0] cmd);
`ifdef ALU_MUL_EN
    return cmd == 4'b1010;
`else
    return 1'b0 && (cmd == 4'b1010);
`endif
  endfunction

  function automatic logic [31:0] mulf(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    return p[31:0];
  endfunction

  function automatic logic f_ready();
    return (!m_valid || out_ready) && !m_busy;
  endfunction

  assign m_next = core(exe_cmd, val1, val2, m_nzcv);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_res <= '0; m_dest <= '0; m_ctl <= '0; m_nzcv <= '0;
      m_busy  <= 1'b0; m_left <= 0;
    end else if (flush) begin
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
    end else if (in_valid && f_ready()) begin
      if (is_mul(exe_cmd)) begin
        m_busy <= 1'b1; m_left <= 32; m_prod <= mulf(val1, val2);
        m_pd <= dest_in; m_pc <= ctl_in; m_ps <= s_bit;
        if (out_ready) m_valid <= 1'b0;
      end else begin
        m_valid <= 1'b1; m_res <= m_next[31:0]; m_dest <= dest_in; m_ctl <= ctl_in;
        if (s_bit) m_nzcv <= m_next[35:32];
      end
    end else if (m_busy && m_left > 0) begin
      m_left <= m_left - 1;
      if (out_ready) m_valid <= 1'b0;
    end else if (m_busy && (!m_valid || out_ready)) begin
      m_busy <= 1'b0; m_valid <= 1'b1; m_res <= m_prod; m_dest <= m_pd; m_ctl <= m_pc;
      if (m_ps) m_nzcv <= {m_prod[31], (m_prod == 32'd0), m_nzcv[1:0]};
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("in_ready", 32'(in_ready), 32'(f_ready()));
      chk("status", 32'(status), 32'(m_nzcv));
      if (m_valid) begin
        chk("alu_res", alu_res, m_res);
        chk("dest_out", 32'(dest_out), 32'(m_dest));
        chk("ctl_out", 32'(ctl_out), 32'(m_ctl));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic v, input logic [3:0] c, input logic s,
                      input logic [31:0] a, input logic [31:0] b, input logic [3:0] d,
                      input logic [2:0] ct, input logic ordy, input logic fl);
    @(posedge clk);
    #2;
    in_valid = v; exe_cmd = c; s_bit = s; val1 = a; val2 = b;
    dest_in = d; ctl_in = ct; out_ready = ordy; flush = fl;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 4'd0, 3'd0, ordy, 1'b0);
  endtask

  int k_seen;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; exe_cmd = '0; s_bit = 1'b0;
    val1 = '0; val2 = '0; dest_in = '0; ctl_in = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // ADDS overflow, then ADC 0+0 without S
    step(1'b1, 4'd2, 1'b1, 32'h7FFF_FFFF, 32'd1, 4'd3, 3'b100, 1'b1, 1'b0);
    step(1'b1, 4'd3, 1'b0, 32'd0, 32'd0, 4'd4, 3'b101, 1'b1, 1'b0);
    @(negedge clk);
    chk("adds_res", alu_res, 32'h8000_0000);
    chk("adds_nzcv", 32'(status), 32'b1001);
    idle(1'b1);
    @(negedge clk);
    chk("adc_res", alu_res, 32'd0);
    chk("adc_nzcv_hold", 32'(status), 32'b1001);

    // SUBS 5-5, then SBC 10-3 with C=1
    step(1'b1, 4'd4, 1'b1, 32'd5, 32'd5, 4'd1, 3'b100, 1'b1, 1'b0);
    step(1'b1, 4'd5, 1'b1, 32'd10, 32'd3, 4'd2, 3'b100, 1'b1, 1'b0);
    @(negedge clk);
    chk("subs_res", alu_res, 32'd0);
    chk("subs_nzcv", 32'(status), 32'b0110);
    idle(1'b1);
    @(negedge clk);
    chk("sbc_res", alu_res, 32'd7);

    // Borrowing SUBS then SBC with C=0, logic ops, carry-in ADC overflow
    step(1'b1, 4'd4, 1'b1, 32'd3, 32'd5, 4'd6, 3'b010, 1'b1, 1'b0);
    step(1'b1, 4'd5, 1'b0, 32'd10, 32'd3, 4'd7, 3'b001, 1'b1, 1'b0);
    step(1'b1, 4'd8, 1'b1, 32'hFF00_FF00, 32'hFFFF_FFFF, 4'd8, 3'b110, 1'b1, 1'b0);
    step(1'b1, 4'd9, 1'b1, 32'd0, 32'd0, 4'd9, 3'b011, 1'b1, 1'b0);
    step(1'b1, 4'd7, 1'b1, 32'h1234_0000, 32'h0000_5678, 4'd10, 3'b111, 1'b1, 1'b0);
    step(1'b1, 4'd1, 1'b1, 32'd9, 32'h0000_00AB, 4'd11, 3'b000, 1'b1, 1'b0);
    step(1'b1, 4'd2, 1'b1, 32'hFFFF_FFFF, 32'd1, 4'd12, 3'b100, 1'b1, 1'b0);
    step(1'b1, 4'd3, 1'b1, 32'h8000_0000, 32'h8000_0000, 4'd13, 3'b100, 1'b1, 1'b0);
    idle(1'b1);
    @(negedge clk);
    chk("adcs_cin_res", alu_res, 32'd1);
    chk("adcs_cin_nzcv", 32'(status), 32'b0011);
    step(1'b1, 4'd0, 1'b1, 32'd4, 32'd4, 4'd14, 3'b100, 1'b1, 1'b0);
    idle(1'b1);
    @(negedge clk);
    chk("undef_res", alu_res, 32'd0);
    chk("undef_nzcv", 32'(status), 32'b0011);

    // Backpressure
    step(1'b1, 4'd2, 1'b0, 32'd1, 32'd2, 4'd1, 3'b100, 1'b1, 1'b0);
    step(1'b1, 4'd2, 1'b0, 32'd10, 32'd20, 4'd2, 3'b010, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_res_stable", alu_res, 32'd3);
    end
    step(1'b1, 4'd2, 1'b0, 32'd10, 32'd20, 4'd2, 3'b010, 1'b1, 1'b0);
    idle(1'b1);
    @(negedge clk);
    chk("bp_next_res", alu_res, 32'd30);

    // Flush discarding ANDS, then flush of a held output
    step(1'b1, 4'd2, 1'b0, 32'd4, 32'd4, 4'd3, 3'b100, 1'b1, 1'b0);
    step(1'b1, 4'd6, 1'b1, 32'hF0, 32'h0F, 4'd5, 3'b100, 1'b1, 1'b1);
    idle(1'b1);
    @(negedge clk);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_nzcv", 32'(status), 32'b0011);
    step(1'b1, 4'd2, 1'b0, 32'd4, 32'd4, 4'd3, 3'b100, 1'b1, 1'b0);
    idle(1'b0);
    step(1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 4'd0, 3'd0, 1'b0, 1'b1);
    idle(1'b0);
    @(negedge clk);
    chk("flush_held_valid", 32'(out_valid), 32'd0);

    // Reset mid-stream
    step(1'b1, 4'd4, 1'b1, 32'd1, 32'd1, 4'd1, 3'b100, 1'b1, 1'b0);
    step(1'b1, 4'd2, 1'b1, 32'd5, 32'd6, 4'd2, 3'b100, 1'b1, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_status", 32'(status), 32'd0);
    idle(1'b1);
    idle(1'b1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);

    // Opcode 1010 after a borrowing SUBS (status 1000)
    step(1'b1, 4'd4, 1'b1, 32'd3, 32'd5, 4'd1, 3'b100, 1'b1, 1'b0);
`ifdef ALU_MUL_EN
    step(1'b1, 4'b1010, 1'b1, 32'h0001_0000, 32'h0001_0000, 4'd5, 3'b100, 1'b1, 1'b0);
    idle(1'b1);
    k_seen = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        k_seen = k;
        break;
      end
      if (k == 1) chk("mul_in_ready", 32'(in_ready), 32'd0);
    end
    chk("mul_latency", 32'(k_seen), 32'd33);
    chk("mul_res", alu_res, 32'd0);
    chk("mul_nzcv", 32'(status), 32'b0100);
    step(1'b1, 4'b1010, 1'b0, 32'd3, 32'd7, 4'd6, 3'b001, 1'b1, 1'b0);
    idle(1'b1);
    repeat (36) @(posedge clk);
    step(1'b1, 4'b1010, 1'b1, 32'd7, 32'd7, 4'd7, 3'b001, 1'b1, 1'b0);
    idle(1'b1);
    repeat (5) @(posedge clk);
    step(1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 4'd0, 3'd0, 1'b1, 1'b1);
    idle(1'b1);
    repeat (40) @(posedge clk);
    #1;
    chk("mul_abort_valid", 32'(out_valid), 32'd0);
    chk("mul_abort_nzcv", 32'(status), 32'b0100);
`else
    step(1'b1, 4'b1010, 1'b1, 32'd3, 32'd7, 4'd5, 3'b100, 1'b1, 1'b0);
    idle(1'b1);
    @(negedge clk);
    chk("op1010_valid", 32'(out_valid), 32'd1);
    chk("op1010_res", alu_res, 32'd0);
    chk("op1010_nzcv", 32'(status), 32'b1000);
`endif
    idle(1'b1);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
